// File: rtl/seven_seg_pkg.sv
// Shared segment encodings and nibble decode for the seven-segment scanner.
// Cathode vectors are active-low, ordered {g,f,e,d,c,b,a}.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0   = 7'h40;
    localparam seg_t SEG_1   = 7'h79;
    localparam seg_t SEG_2   = 7'h24;
    localparam seg_t SEG_3   = 7'h30;
    localparam seg_t SEG_4   = 7'h19;
    localparam seg_t SEG_5   = 7'h12;
    localparam seg_t SEG_6   = 7'h02;
    localparam seg_t SEG_7   = 7'h78;
    localparam seg_t SEG_8   = 7'h00;
    localparam seg_t SEG_9   = 7'h10;
    localparam seg_t SEG_A   = 7'h08;
    localparam seg_t SEG_B   = 7'h03;
    localparam seg_t SEG_C   = 7'h46;
    localparam seg_t SEG_D   = 7'h21;
    localparam seg_t SEG_E   = 7'h06;
    localparam seg_t SEG_F   = 7'h0E;
    localparam seg_t SEG_OFF = 7'h7F;

    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        seg_t seg;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment cathode pattern.
module seven_seg_hex_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = hex_to_seg(i_nibble);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode scanner with frame snapshot, blanking,
// decimal points, PWM brightness and a per-slot ghosting guard cycle.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SLOT_CYCLES = 16,
    parameter int BRIGHT_W    = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              cathode,
    output logic                    dp_n,
    output logic                    frame_tick
);

    localparam int SLOT_W = $clog2(SLOT_CYCLES);
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    logic [SLOT_W-1:0]       r_slot_cnt;
    logic [IDX_W-1:0]        r_digit_idx;
    logic [4*NUM_DIGITS-1:0] r_digits_snap;
    logic [NUM_DIGITS-1:0]   r_dp_snap;
    logic [NUM_DIGITS-1:0]   r_en_snap;
    logic [BRIGHT_W-1:0]     r_bright_snap;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic [6:0]              r_cathode;
    logic                    r_dp_n;
    logic                    r_frame_tick;

    logic                  w_slot_last;
    logic                  w_idx_last;
    logic                  w_frame_start;
    logic                  w_frame_last;
    logic [3:0]            w_nibble;
    logic                  w_cur_en;
    logic                  w_cur_dp;
    logic [NUM_DIGITS-1:0] w_anode_sel;
    logic                  w_guard;
    logic                  w_duty_on;
    logic                  w_lit;
    logic [6:0]            w_seg;

    always_comb begin
        w_slot_last   = (r_slot_cnt == SLOT_W'(SLOT_CYCLES - 1));
        w_idx_last    = (r_digit_idx == IDX_W'(NUM_DIGITS - 1));
        w_frame_start = (r_slot_cnt == '0) && (r_digit_idx == '0);
        w_frame_last  = w_slot_last && w_idx_last;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_slot_cnt  <= '0;
            r_digit_idx <= '0;
        end else if (w_slot_last) begin
            r_slot_cnt  <= '0;
            r_digit_idx <= w_idx_last ? '0 : r_digit_idx + IDX_W'(1);
        end else begin
            r_slot_cnt  <= r_slot_cnt + SLOT_W'(1);
        end
    end

    // Inputs are captured only at frame start so a frame never tears.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_digits_snap <= '0;
            r_dp_snap     <= '0;
            r_en_snap     <= '0;
            r_bright_snap <= '0;
        end else if (w_frame_start) begin
            r_digits_snap <= digits;
            r_dp_snap     <= dp;
            r_en_snap     <= digit_en;
            r_bright_snap <= brightness;
        end
    end

    always_comb begin
        w_nibble    = '0;
        w_cur_en    = 1'b0;
        w_cur_dp    = 1'b0;
        w_anode_sel = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit_idx == IDX_W'(i)) begin
                w_nibble       = r_digits_snap[4*i +: 4];
                w_cur_en       = r_en_snap[i];
                w_cur_dp       = r_dp_snap[i];
                w_anode_sel[i] = 1'b0;
            end
        end
    end

    // Slot cycle 0 keeps all anodes off so the previous digit's
    // segments never bleed into the next one.
    always_comb begin
        w_guard   = (r_slot_cnt == '0);
        w_duty_on = (r_slot_cnt[BRIGHT_W-1:0] <= r_bright_snap);
        w_lit     = !w_guard && w_duty_on && w_cur_en;
    end

    seven_seg_hex_decoder u_hex_decoder (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_anode      <= '1;
            r_cathode    <= SEG_OFF;
            r_dp_n       <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_anode      <= w_lit ? w_anode_sel : '1;
            r_cathode    <= w_lit ? w_seg : SEG_OFF;
            r_dp_n       <= w_lit ? ~w_cur_dp : 1'b1;
            r_frame_tick <= w_frame_last;
        end
    end

    assign anode      = r_anode;
    assign cathode    = r_cathode;
    assign dp_n       = r_dp_n;
    assign frame_tick = r_frame_tick;

endmodule
